// File: rtl/servo_pkg.sv
// Shared definitions for the servo waypoint sequencer: level width, default clamp and FSM states.
package servo_pkg;

   localparam int unsigned LEVEL_W       = 10;
   localparam int unsigned LEVEL_MAX_DEF = 1000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DWELL  = 2'd2,
      ST_MANUAL = 2'd3
   } state_t;

   // Saturate a requested level at the legal maximum.
   function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl,
                                                      input logic [LEVEL_W-1:0] lim);
      return (lvl > lim) ? lim : lvl;
   endfunction

endpackage

// File: rtl/servo_wp_table.sv
// Waypoint register file: clamped synchronous write, cleared on reset, asynchronous read.
module servo_wp_table
   import servo_pkg::*;
#(
   parameter  int unsigned NUM_WP    = 4,
   parameter  int unsigned LEVEL_MAX = LEVEL_MAX_DEF,
   localparam int unsigned IDX_W     = $clog2(NUM_WP)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [IDX_W-1:0]   addr,
   input  logic [LEVEL_W-1:0] data,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [LEVEL_W-1:0] rd_data
);

   logic [LEVEL_W-1:0] mem [NUM_WP];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[addr] <= clamp_level(data, LEVEL_W'(LEVEL_MAX));
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/servo_seq_ctrl.sv
// Servo waypoint sequencer: steps through a table of duty levels with a fixed dwell,
// with stop/abort, optional looping and a preempting manual override.
module servo_seq_ctrl
   import servo_pkg::*;
#(
   parameter  int unsigned NUM_WP      = 4,
   parameter  int unsigned DWELL_TICKS = 50_000_000,
   parameter  int unsigned LEVEL_MAX   = LEVEL_MAX_DEF,
   localparam int unsigned IDX_W       = $clog2(NUM_WP)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic               man_req,
   input  logic [LEVEL_W-1:0] man_level,
   input  logic               wp_we,
   input  logic [IDX_W-1:0]   wp_addr,
   input  logic [LEVEL_W-1:0] wp_data,
   output logic [LEVEL_W-1:0] duty_level,
   output logic               man_gnt,
   output logic               busy,
   output logic               seq_done,
   output logic [IDX_W-1:0]   cur_wp
);

   localparam int unsigned       CNT_W    = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_TICKS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_WP - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   dwell_cnt, cnt_nxt;
   logic [LEVEL_W-1:0] duty_nxt;
   logic [LEVEL_W-1:0] wp_rd;
   logic               done_nxt;
   logic               dwell_end;

   servo_wp_table #(
      .NUM_WP    (NUM_WP),
      .LEVEL_MAX (LEVEL_MAX)
   ) u_wp_table (
      .clk     (clk),
      .rst     (rst),
      .we      (wp_we),
      .addr    (wp_addr),
      .data    (wp_data),
      .rd_idx  (idx),
      .rd_data (wp_rd)
   );

   assign dwell_end = (dwell_cnt == CNT_LAST);
   assign cur_wp    = idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         dwell_cnt  <= '0;
         duty_level <= '0;
         man_gnt    <= 1'b0;
         busy       <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         dwell_cnt  <= cnt_nxt;
         duty_level <= duty_nxt;
         man_gnt    <= (state_nxt == ST_MANUAL);
         busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_DWELL);
         seq_done   <= done_nxt;
      end
   end

   // Manual request outranks stop, which outranks dwell expiry.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = dwell_cnt;
      duty_nxt  = duty_level;
      done_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (man_req) begin
               state_nxt = ST_MANUAL;
            end else if (start) begin
               state_nxt = ST_LOAD;
               idx_nxt   = '0;
            end
         end
         ST_LOAD: begin
            if (man_req) begin
               state_nxt = ST_MANUAL;
               idx_nxt   = '0;
            end else if (stop) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end else begin
               duty_nxt  = wp_rd;
               cnt_nxt   = '0;
               state_nxt = ST_DWELL;
            end
         end
         ST_DWELL: begin
            if (man_req) begin
               state_nxt = ST_MANUAL;
               idx_nxt   = '0;
            end else if (stop) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end else if (dwell_end) begin
               if (idx != IDX_LAST) begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = ST_LOAD;
               end else if (loop_en) begin
                  idx_nxt   = '0;
                  state_nxt = ST_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = dwell_cnt + CNT_W'(1);
            end
         end
         ST_MANUAL: begin
            if (!man_req) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // The manual level is tracked on entry to and every cycle within MANUAL.
      if (state_nxt == ST_MANUAL) begin
         duty_nxt = clamp_level(man_level, LEVEL_W'(LEVEL_MAX));
      end
   end

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Scoreboard bench for servo_seq_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them, and directed scenarios add fixed-value spot checks.
module tb_servo_seq_ctrl;

   localparam int unsigned NWP   = 4;
   localparam int unsigned DWELL = 10;
   localparam int unsigned LMAX  = 1000;

   typedef struct packed {
      logic [9:0] duty;
      logic       gnt;
      logic       busy;
      logic       done;
      logic [1:0] wp;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       start, stop, loop_en, man_req, wp_we;
   logic [9:0] man_level, wp_data;
   logic [1:0] wp_addr;
   logic [9:0] duty_level;
   logic       man_gnt, busy, seq_done;
   logic [1:0] cur_wp;

   int   n_cmp = 0;
   int   n_err = 0;
   obs_t exp_q[$];

   // Model state: sequence running, manual active, current entry, cycles since its load.
   bit          m_seq, m_man, m_done;
   int unsigned m_entry, m_age, m_duty;
   int unsigned m_tab[NWP];

   servo_seq_ctrl #(
      .NUM_WP      (NWP),
      .DWELL_TICKS (DWELL),
      .LEVEL_MAX   (LMAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .man_req    (man_req),
      .man_level  (man_level),
      .wp_we      (wp_we),
      .wp_addr    (wp_addr),
      .wp_data    (wp_data),
      .duty_level (duty_level),
      .man_gnt    (man_gnt),
      .busy       (busy),
      .seq_done   (seq_done),
      .cur_wp     (cur_wp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned clampv(input int unsigned v);
      return (v > LMAX) ? LMAX : v;
   endfunction

   task automatic model_reset();
      m_seq = 0; m_man = 0; m_done = 0;
      m_entry = 0; m_age = 0; m_duty = 0;
      for (int i = 0; i < NWP; i++) m_tab[i] = 0;
   endtask

   task automatic model_step();
      int unsigned tab_next[NWP];
      tab_next = m_tab;
      if (wp_we) tab_next[wp_addr] = clampv(32'(wp_data));
      m_done = 0;
      if (m_man) begin
         if (!man_req) m_man = 0;
         else m_duty = clampv(32'(man_level));
      end else if (m_seq) begin
         if (man_req) begin
            m_seq = 0; m_entry = 0; m_man = 1; m_duty = clampv(32'(man_level));
         end else if (stop) begin
            m_seq = 0; m_entry = 0;
         end else if (m_age == 0) begin
            m_duty = m_tab[m_entry];
            m_age  = 1;
         end else if (m_age == DWELL) begin
            if (m_entry < NWP - 1) begin
               m_entry++; m_age = 0;
            end else if (loop_en) begin
               m_entry = 0; m_age = 0;
            end else begin
               m_seq = 0; m_done = 1;
            end
         end else begin
            m_age++;
         end
      end else begin
         if (man_req) begin
            m_man = 1; m_duty = clampv(32'(man_level));
         end else if (start) begin
            m_seq = 1; m_entry = 0; m_age = 0;
         end
      end
      m_tab = tab_next;
   endtask

   // One clock: model consumes the inputs seen at the edge, expectation is queued, pulses drop.
   task automatic cycle();
      obs_t e;
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
      e = {10'(m_duty), m_man, m_seq, m_done, 2'(m_entry)};
      exp_q.push_back(e);
      #1;
      start = 0; stop = 0; wp_we = 0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [9:0] d);
      wp_we = 1; wp_addr = a; wp_data = d;
      cycle();
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      obs_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {duty_level, man_gnt, busy, seq_done, cur_wp};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got duty=%0d gnt=%0b busy=%0b done=%0b wp=%0d, expected duty=%0d gnt=%0b busy=%0b done=%0b wp=%0d",
                     $time, a.duty, a.gnt, a.busy, a.done, a.wp, e.duty, e.gnt, e.busy, e.done, e.wp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time budget exceeded");
      $fatal(1);
   end

   initial begin
      int done_cnt;
      rst = 0; start = 0; stop = 0; loop_en = 0; man_req = 0; wp_we = 0;
      man_level = '0; wp_data = '0; wp_addr = '0;
      model_reset();
      #1;
      chk("reset_duty", 32'(duty_level), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_gnt", 32'(man_gnt), 0);
      repeat (2) cycle();
      @(negedge clk); #1; rst = 1;

      // Basic one-shot sequence.
      wr(2'd0, 10'd100); wr(2'd1, 10'd500); wr(2'd2, 10'd900); wr(2'd3, 10'd300);
      loop_en = 0; start = 1; cycle();
      chk("seq_k0_busy", 32'(busy), 1);
      done_cnt = 0;
      for (int k = 1; k <= 46; k++) begin
         cycle();
         done_cnt += int'(seq_done);
         case (k)
            1:  chk("seq_k1_duty", 32'(duty_level), 100);
            11: chk("seq_k11_duty", 32'(duty_level), 100);
            12: chk("seq_k12_duty", 32'(duty_level), 500);
            22: chk("seq_k22_duty", 32'(duty_level), 500);
            23: chk("seq_k23_duty", 32'(duty_level), 900);
            34: chk("seq_k34_duty", 32'(duty_level), 300);
            43: chk("seq_k43_busy", 32'(busy), 1);
            44: begin
               chk("seq_k44_done", 32'(seq_done), 1);
               chk("seq_k44_busy", 32'(busy), 0);
               chk("seq_k44_duty", 32'(duty_level), 300);
            end
            default: ;
         endcase
      end
      chk("seq_done_count", 32'(done_cnt), 1);

      // Looping, mid-dwell rewrite of entry 1, then manual preemption during entry 2.
      done_cnt = 0;
      loop_en = 1; start = 1; cycle();
      for (int k = 1; k <= 120; k++) begin
         if (k == 57) begin wp_we = 1; wp_addr = 2'd1; wp_data = 10'd700; end
         if (k == 113) begin man_req = 1; man_level = 10'd1023; end
         if (k == 116) man_req = 0;
         cycle();
         done_cnt += int'(seq_done);
         case (k)
            44: chk("loop_k44_wp", 32'(cur_wp), 0);
            45: begin
               chk("loop_k45_duty", 32'(duty_level), 100);
               chk("loop_k45_wp", 32'(cur_wp), 0);
            end
            60:  chk("wr_k60_duty", 32'(duty_level), 500);
            66:  chk("wr_k66_duty", 32'(duty_level), 500);
            100: chk("wr_k100_duty", 32'(duty_level), 700);
            113: begin
               chk("pre_gnt", 32'(man_gnt), 1);
               chk("pre_duty", 32'(duty_level), 1000);
               chk("pre_busy", 32'(busy), 0);
            end
            116: begin
               chk("pre_exit_gnt", 32'(man_gnt), 0);
               chk("pre_exit_duty", 32'(duty_level), 1000);
               chk("pre_exit_wp", 32'(cur_wp), 0);
            end
            default: ;
         endcase
      end
      chk("loop_done_count", 32'(done_cnt), 0);

      // Start and man_req together, then stop mid-dwell.
      loop_en = 0; start = 1; man_req = 1; man_level = 10'd200; cycle();
      chk("sim_gnt", 32'(man_gnt), 1);
      chk("sim_busy", 32'(busy), 0);
      chk("sim_duty", 32'(duty_level), 200);
      man_req = 0; cycle();
      start = 1; cycle();
      repeat (4) cycle();
      stop = 1; cycle();
      chk("stop_busy", 32'(busy), 0);
      chk("stop_duty", 32'(duty_level), 100);
      chk("stop_done", 32'(seq_done), 0);
      cycle();
      chk("stop_done_after", 32'(seq_done), 0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 15) == 0);
         stop  = ($urandom_range(0, 150) == 0);
         if ($urandom_range(0, 30) == 0) loop_en = ~loop_en;
         if ($urandom_range(0, 60) == 0) begin
            man_req = ~man_req;
            if (man_req) man_level = 10'($urandom_range(0, 1023));
         end
         if ($urandom_range(0, 7) == 0) begin
            wp_we = 1; wp_addr = 2'($urandom_range(0, 3)); wp_data = 10'($urandom_range(0, 1023));
         end
         cycle();
      end

      // Asynchronous reset in the middle of a dwell.
      man_req = 0; loop_en = 0; stop = 1; cycle(); cycle();
      wr(2'd0, 10'd600);
      start = 1; cycle();
      repeat (5) cycle();
      chk("rst_pre_duty", 32'(duty_level), 600);
      @(negedge clk); #1;
      rst = 0; model_reset();
      #1;
      chk("rst_async_duty", 32'(duty_level), 0);
      chk("rst_async_busy", 32'(busy), 0);
      chk("rst_async_wp", 32'(cur_wp), 0);
      repeat (2) cycle();
      @(negedge clk); #1; rst = 1;
      start = 1; cycle();
      for (int k = 1; k <= 50; k++) begin
         cycle();
         if (k == 1)  chk("rst_tab0_cleared", 32'(duty_level), 0);
         if (k == 12) chk("rst_tab1_cleared", 32'(duty_level), 0);
      end

      @(negedge clk); #1;
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
